// File: rtl/codestream_byte_serializer.sv
// rtl/codestream_byte_serializer.sv - 16-bit codestream word FIFO, big-endian byte serializer and EOC frame counter
module codestream_byte_serializer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          cntrl0_reset_tb,
  input  logic [15:0]   code_stream,
  input  logic          code_stream_valid,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  output logic          frame_done,
  output logic [31:0]   frame_bytes
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;

  state_t        state_q;
  logic [7:0]    byte_q;
  logic [7:0]    lo_byte_q;
  logic          valid_q;

  logic          overflow_q;
  logic          frame_done_q;
  logic [31:0]   frame_bytes_q;
  logic [31:0]   count_q;
  logic [7:0]    prev_q;

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          eoc;
  logic [15:0]   head;

  assign full   = (level_q == FULL_LEVEL);
  assign empty  = (level_q == '0);
  assign accept = valid_q & byte_ready;
  // A full FIFO drops the incoming word even when a pop frees a slot this cycle.
  assign push   = code_stream_valid & ~full;
  assign pop    = ~empty & ((state_q == S_IDLE) | ((state_q == S_LO) & accept));
  assign head   = mem_q[rd_ptr_q];
  assign eoc    = accept & (prev_q == 8'hFF) & (byte_q == 8'hD9);

  // Next occupancy from the push/pop pair; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (!push && pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  // Word storage; stale contents are harmless because the pointers are reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= code_stream;
    end
  end

  // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge cntrl0_reset_tb) begin
    if (cntrl0_reset_tb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Serializer FSM: high byte first, low byte held for the second beat, reload straight from LO.
  always_ff @(posedge clock or posedge cntrl0_reset_tb) begin
    if (cntrl0_reset_tb) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      lo_byte_q <= 8'h00;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            byte_q    <= head[15:8];
            lo_byte_q <= head[7:0];
            valid_q   <= 1'b1;
            state_q   <= S_HI;
          end
        end
        S_HI: begin
          if (accept) begin
            byte_q  <= lo_byte_q;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            if (!empty) begin
              byte_q    <= head[15:8];
              lo_byte_q <= head[7:0];
              state_q   <= S_HI;
            end else begin
              byte_q  <= 8'h00;
              valid_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          byte_q  <= 8'h00;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow, running byte count and FF-D9 end-of-codestream detection on accepted bytes.
  always_ff @(posedge clock or posedge cntrl0_reset_tb) begin
    if (cntrl0_reset_tb) begin
      overflow_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= 32'd0;
      count_q       <= 32'd0;
      prev_q        <= 8'h00;
    end else begin
      overflow_q   <= overflow_q | (code_stream_valid & full);
      frame_done_q <= eoc;
      if (accept) begin
        if (eoc) begin
          frame_bytes_q <= count_q + 32'd1;
          count_q       <= 32'd0;
          prev_q        <= 8'h00;
        end else begin
          count_q <= count_q + 32'd1;
          prev_q  <= byte_q;
        end
      end
    end
  end

  assign byte_out    = byte_q;
  assign byte_valid  = valid_q;
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;
  assign frame_done  = frame_done_q;
  assign frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_codestream_byte_serializer.sv
// tb/tb_codestream_byte_serializer.sv - self-checking bench for codestream_byte_serializer
module tb_codestream_byte_serializer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          cntrl0_reset_tb = 1'b1;
  logic [15:0]   code_stream = 16'h0000;
  logic          code_stream_valid = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          frame_done;
  logic [31:0]   frame_bytes;

  codestream_byte_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock             (clock),
    .cntrl0_reset_tb   (cntrl0_reset_tb),
    .code_stream       (code_stream),
    .code_stream_valid (code_stream_valid),
    .byte_out          (byte_out),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .fifo_level        (fifo_level),
    .overflow          (overflow),
    .frame_done        (frame_done),
    .frame_bytes       (frame_bytes)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every accepted byte is compared against the next expected byte.
  always @(negedge clock) begin
    if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte actual=%0h expected=none", byte_out);
      end else begin
        mon_exp = sb_q.pop_front();
        check("scoreboard_byte", {24'd0, byte_out}, {24'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w, input logic expect_out);
    if (expect_out) begin
      sb_q.push_back(w[15:8]);
      sb_q.push_back(w[7:0]);
    end
    code_stream       = w;
    code_stream_valid = 1'b1;
    tick();
    code_stream_valid = 1'b0;
  endtask

  task automatic do_reset();
    cntrl0_reset_tb = 1'b1;
    tick();
    tick();
    cntrl0_reset_tb = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check({name, "_drain_left"}, sb_q.size(), 0);
    tick();
    check({name, "_idle_valid"}, {31'd0, byte_valid}, 32'd0);
  endtask

  task automatic wait_byte(input logic [7:0] b, input string name);
    int n;
    n = 0;
    while (!(byte_valid === 1'b1 && byte_out === b) && n < 50) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, {31'd0, (n < 50)}, 32'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int   run;
    int   n;
    logic gap;

    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h0000, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h8001, 8'h80, 8'h01};
    vecs[4] = '{16'hFF00, 8'hFF, 8'h00};
    vecs[5] = '{16'h7E81, 8'h7E, 8'h81};
    vecs[6] = '{16'hC3D9, 8'hC3, 8'hD9};

    // Reset state, sampled between edges while reset is held.
    #12;
    check("rst_byte_valid",  {31'd0, byte_valid}, 32'd0);
    check("rst_byte_out",    {24'd0, byte_out}, 32'd0);
    check("rst_fifo_level",  {25'd0, fifo_level}, 32'd0);
    check("rst_overflow",    {31'd0, overflow}, 32'd0);
    check("rst_frame_done",  {31'd0, frame_done}, 32'd0);
    check("rst_frame_bytes", frame_bytes, 32'd0);
    @(posedge clock);
    #1;
    cntrl0_reset_tb = 1'b0;

    // Single word: first byte in the second cycle after the push.
    byte_ready = 1'b1;
    push_word(16'h1234, 1'b1);
    check("single_lat_c1_valid", {31'd0, byte_valid}, 32'd0);
    check("single_lat_c1_level", {25'd0, fifo_level}, 32'd1);
    tick();
    check("single_c2_valid", {31'd0, byte_valid}, 32'd1);
    check("single_c2_byte",  {24'd0, byte_out}, 32'h12);
    tick();
    check("single_c3_valid", {31'd0, byte_valid}, 32'd1);
    check("single_c3_byte",  {24'd0, byte_out}, 32'h34);
    tick();
    check("single_c4_valid", {31'd0, byte_valid}, 32'd0);
    check("single_queue_empty", sb_q.size(), 0);

    // Table-driven stream with ready held high: one byte per cycle, no bubble.
    run = 0;
    gap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(vecs[i].exp_hi);
      sb_q.push_back(vecs[i].exp_lo);
      push_word(vecs[i].word, 1'b0);
      if (byte_valid) run++;
      else if (run != 0) gap = 1'b1;
    end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (byte_valid) run++;
      else break;
    end
    check("table_gap", {31'd0, gap}, 32'd0);
    check("table_run_length", run, 14);
    wait_drain("table");

    // Backpressure: high byte held for five cycles, then four bytes back-to-back.
    byte_ready = 1'b0;
    push_word(16'hABCD, 1'b1);
    push_word(16'h0102, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {31'd0, byte_valid}, 32'd1);
      check("bp_hold_byte",  {24'd0, byte_out}, 32'hAB);
      tick();
    end
    byte_ready = 1'b1;
    run = 0;
    n = 0;
    while (n < 20) begin
      if (byte_valid) run++;
      else if (run > 0) break;
      tick();
      n++;
    end
    check("bp_run_length", run, 4);
    wait_drain("bp");

    // Overflow: one word sits in the byte holding register, so DEPTH+1 words
    // exactly fill the FIFO and the next one is dropped.
    do_reset();
    byte_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      push_word(16'h1000 + 16'(i), 1'b1);
    end
    check("ovf_full_level", {25'd0, fifo_level}, DEPTH);
    check("ovf_not_yet",    {31'd0, overflow}, 32'd0);
    push_word(16'hDEAD, 1'b0);
    check("ovf_level_after_drop", {25'd0, fifo_level}, DEPTH);
    check("ovf_set",              {31'd0, overflow}, 32'd1);
    byte_ready = 1'b1;
    tick();
    // Push into a full FIFO on the same edge as a pop: still dropped.
    code_stream       = 16'hBEEF;
    code_stream_valid = 1'b1;
    tick();
    code_stream_valid = 1'b0;
    check("ovf_push_pop_level", {25'd0, fifo_level}, DEPTH - 1);
    wait_drain("ovf");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Aligned end-of-codestream marker.
    do_reset();
    byte_ready = 1'b1;
    push_word(16'hFF4F, 1'b1);
    push_word(16'hFF51, 1'b1);
    push_word(16'hFFD9, 1'b1);
    wait_byte(8'hD9, "eoc_al");
    check("eoc_al_pre_done", {31'd0, frame_done}, 32'd0);
    tick();
    check("eoc_al_done",  {31'd0, frame_done}, 32'd1);
    check("eoc_al_bytes", frame_bytes, 32'd6);
    tick();
    check("eoc_al_done_pulse", {31'd0, frame_done}, 32'd0);
    check("eoc_al_bytes_hold", frame_bytes, 32'd6);
    wait_drain("eoc_al");

    // Unaligned marker across a word boundary; the next frame starts at the 0xAA byte.
    do_reset();
    push_word(16'h00FF, 1'b1);
    push_word(16'hD9AA, 1'b1);
    push_word(16'h12FF, 1'b1);
    push_word(16'hD900, 1'b1);
    wait_byte(8'hD9, "eoc_un1");
    tick();
    check("eoc_un1_done",  {31'd0, frame_done}, 32'd1);
    check("eoc_un1_bytes", frame_bytes, 32'd3);
    tick();
    check("eoc_un1_pulse", {31'd0, frame_done}, 32'd0);
    wait_byte(8'hD9, "eoc_un2");
    tick();
    check("eoc_un2_done",  {31'd0, frame_done}, 32'd1);
    check("eoc_un2_bytes", frame_bytes, 32'd4);
    wait_drain("eoc_un");

    // Reset in LO with words stored: everything is discarded immediately.
    byte_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_word(16'h2000 + 16'(i), 1'b0);
    end
    sb_q.push_back(8'h20);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("mid_lo_byte",  {24'd0, byte_out}, 32'h00);
    check("mid_lo_level", {25'd0, fifo_level}, 32'd9);
    #2;
    cntrl0_reset_tb = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    check("mid_rst_level", {25'd0, fifo_level}, 32'd0);
    check("mid_rst_byte",  {24'd0, byte_out}, 32'd0);
    code_stream       = 16'h7777;
    code_stream_valid = 1'b1;
    tick();
    tick();
    code_stream_valid = 1'b0;
    cntrl0_reset_tb   = 1'b0;
    check("mid_rst_ignore_push", {25'd0, fifo_level}, 32'd0);
    check("mid_rst_queue", sb_q.size(), 0);
    byte_ready = 1'b1;
    push_word(16'h5566, 1'b1);
    wait_drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
